// File: rtl/prco_fetch_arb.sv
// Fetch / load-store arbiter in front of the local on-chip memory: owns the PC,
// issues one-cycle strobes, collects acks, squashes stale fetches, times out lost acks.
module prco_fetch_arb #(
   parameter logic [15:0] P_RESET_VECTOR = 16'h0000,
   parameter int          P_ACK_TIMEOUT  = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_fetch_en,
   input  logic        i_branch_valid,
   input  logic [15:0] i_branch_target,
   input  logic        i_ls_req,
   input  logic        i_ls_we,
   input  logic [15:0] i_ls_addr,
   input  logic [15:0] i_ls_wdata,
   output logic        q_ce_fetch,
   output logic        q_ce_alu,
   output logic        q_mem_we,
   output logic [15:0] q_mem_addr,
   output logic [15:0] q_mem_dina,
   input  logic        i_mem_ack_dec,
   input  logic        i_mem_ack_reg,
   input  logic [15:0] i_mem_douta,
   output logic [15:0] q_instr,
   output logic [15:0] q_instr_pc,
   output logic        q_instr_valid,
   output logic [15:0] q_ls_rdata,
   output logic        q_ls_done,
   output logic        q_err,
   output logic [15:0] q_pc,
   output logic        q_busy
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LS} state_e;

   localparam logic [8:0] TMO = 9'(P_ACK_TIMEOUT);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] fetch_pc_q, fetch_pc_d;
   logic        squash_q, squash_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ce_fetch_q, ce_fetch_d;
   logic        ce_alu_q, ce_alu_d;
   logic        mem_we_q, mem_we_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_dina_q, mem_dina_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [15:0] ls_rdata_q, ls_rdata_d;
   logic        ls_done_q, ls_done_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        tmo_hit;

   // Terminal count is reached when this cycle's increment would hit the limit.
   assign tmo_hit = ({1'b0, cnt_q} + 9'd1) == TMO;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      squash_d      = squash_q;
      cnt_d         = cnt_q;
      ce_fetch_d    = 1'b0;
      ce_alu_d      = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_dina_d    = mem_dina_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      ls_rdata_d    = ls_rdata_q;
      ls_done_d     = 1'b0;
      err_d         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_ls_req) begin
               ce_alu_d   = 1'b1;
               mem_we_d   = i_ls_we;
               mem_addr_d = i_ls_addr;
               mem_dina_d = i_ls_wdata;
               cnt_d      = 8'd0;
               state_d    = S_LS;
            end else if (i_fetch_en && !i_branch_valid) begin
               ce_fetch_d = 1'b1;
               mem_addr_d = pc_q;
               fetch_pc_d = pc_q;
               cnt_d      = 8'd0;
               squash_d   = 1'b0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            if (i_mem_ack_dec) begin
               // A redirect landing with the ack also makes the word stale.
               if (!(squash_q || i_branch_valid)) begin
                  instr_d       = i_mem_douta;
                  instr_pc_d    = fetch_pc_q;
                  instr_valid_d = 1'b1;
                  pc_d          = pc_q + 16'd1;
               end
               squash_d = 1'b0;
               state_d  = S_IDLE;
            end else if (tmo_hit) begin
               err_d    = 1'b1;
               squash_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (i_branch_valid) squash_d = 1'b1;
            end
         end
         S_LS: begin
            if (i_mem_ack_reg) begin
               ls_rdata_d = i_mem_douta;
               ls_done_d  = 1'b1;
               state_d    = S_IDLE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Redirect wins over the post-fetch increment in every state.
      if (i_branch_valid) pc_d = i_branch_target;

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q       <= S_IDLE;
         pc_q          <= P_RESET_VECTOR;
         fetch_pc_q    <= 16'h0000;
         squash_q      <= 1'b0;
         cnt_q         <= 8'd0;
         ce_fetch_q    <= 1'b0;
         ce_alu_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 16'h0000;
         mem_dina_q    <= 16'h0000;
         instr_q       <= 16'h0000;
         instr_pc_q    <= 16'h0000;
         instr_valid_q <= 1'b0;
         ls_rdata_q    <= 16'h0000;
         ls_done_q     <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         squash_q      <= squash_d;
         cnt_q         <= cnt_d;
         ce_fetch_q    <= ce_fetch_d;
         ce_alu_q      <= ce_alu_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_dina_q    <= mem_dina_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         ls_rdata_q    <= ls_rdata_d;
         ls_done_q     <= ls_done_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
      end
   end

   assign q_ce_fetch    = ce_fetch_q;
   assign q_ce_alu      = ce_alu_q;
   assign q_mem_we      = mem_we_q;
   assign q_mem_addr    = mem_addr_q;
   assign q_mem_dina    = mem_dina_q;
   assign q_instr       = instr_q;
   assign q_instr_pc    = instr_pc_q;
   assign q_instr_valid = instr_valid_q;
   assign q_ls_rdata    = ls_rdata_q;
   assign q_ls_done     = ls_done_q;
   assign q_err         = err_q;
   assign q_pc          = pc_q;
   assign q_busy        = busy_q;

endmodule

// File: tb/tb_prco_fetch_arb.sv
// Directed bench for prco_fetch_arb: one instance at reset vector 0, one at FFFF,
// both behind a shared one-cycle-latency memory model.
module tb_prco_fetch_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // main instance (reset vector 0000)
   logic        rst_n = 1'b0, fetch_en = 1'b0, br_v = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [15:0] br_t = 16'h0, ls_addr = 16'h0, ls_wdata = 16'h0;
   logic        ce_fetch, ce_alu, mem_we, instr_valid, ls_done, err, busy;
   logic [15:0] mem_addr, mem_dina, instr, instr_pc, ls_rdata, pc;
   logic        ack_dec = 1'b0, ack_reg = 1'b0;
   logic [15:0] douta = 16'h0;

   // second instance (reset vector FFFF), fetch only
   logic        rst2_n = 1'b0, fetch_en2 = 1'b0;
   logic        ce_fetch2, ce_alu2, mem_we2, instr_valid2, ls_done2, err2, busy2;
   logic [15:0] mem_addr2, mem_dina2, instr2, instr_pc2, ls_rdata2, pc2;
   logic        ack_dec2 = 1'b0, ack_reg2 = 1'b0;
   logic [15:0] douta2 = 16'h0;

   logic [15:0] mem [0:65535];
   logic        suppress = 1'b0;
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;
   logic [15:0] exp_w [0:2];

   prco_fetch_arb #(.P_RESET_VECTOR(16'h0000), .P_ACK_TIMEOUT(15)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_fetch_en(fetch_en),
      .i_branch_valid(br_v), .i_branch_target(br_t),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .q_ce_fetch(ce_fetch), .q_ce_alu(ce_alu), .q_mem_we(mem_we),
      .q_mem_addr(mem_addr), .q_mem_dina(mem_dina),
      .i_mem_ack_dec(ack_dec), .i_mem_ack_reg(ack_reg), .i_mem_douta(douta),
      .q_instr(instr), .q_instr_pc(instr_pc), .q_instr_valid(instr_valid),
      .q_ls_rdata(ls_rdata), .q_ls_done(ls_done), .q_err(err), .q_pc(pc), .q_busy(busy)
   );

   prco_fetch_arb #(.P_RESET_VECTOR(16'hFFFF), .P_ACK_TIMEOUT(15)) dut2 (
      .i_clk(clk), .i_reset(rst2_n), .i_fetch_en(fetch_en2),
      .i_branch_valid(1'b0), .i_branch_target(16'h0000),
      .i_ls_req(1'b0), .i_ls_we(1'b0), .i_ls_addr(16'h0000), .i_ls_wdata(16'h0000),
      .q_ce_fetch(ce_fetch2), .q_ce_alu(ce_alu2), .q_mem_we(mem_we2),
      .q_mem_addr(mem_addr2), .q_mem_dina(mem_dina2),
      .i_mem_ack_dec(ack_dec2), .i_mem_ack_reg(ack_reg2), .i_mem_douta(douta2),
      .q_instr(instr2), .q_instr_pc(instr_pc2), .q_instr_valid(instr_valid2),
      .q_ls_rdata(ls_rdata2), .q_ls_done(ls_done2), .q_err(err2), .q_pc(pc2), .q_busy(busy2)
   );

   // Memory: strobe registered on the next edge, ack/data visible the cycle after.
   always @(posedge clk) begin
      ack_dec  <= ce_fetch & ~suppress;
      ack_reg  <= ce_alu;
      douta    <= mem[mem_addr];
      ack_dec2 <= ce_fetch2;
      ack_reg2 <= ce_alu2;
      douta2   <= mem[mem_addr2];
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ce_alu && mem_we) mem[mem_addr] <= mem_dina;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick;
      pl_en = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++;
      if ({ce_fetch, ce_alu, mem_we, instr_valid, ls_done, err, busy} !== 7'b0) begin
         n_fail++; $display("FAIL reset_strobes: got %b want 0000000",
                            {ce_fetch, ce_alu, mem_we, instr_valid, ls_done, err, busy});
      end
      n_tests++;
      if ({mem_addr, mem_dina, instr, instr_pc, ls_rdata, pc} !== 96'h0) begin
         n_fail++; $display("FAIL reset_data: got %h want all zero",
                            {mem_addr, mem_dina, instr, instr_pc, ls_rdata, pc});
      end
      n_tests++;
      if (pc2 !== 16'hFFFF) begin
         n_fail++; $display("FAIL reset_vector_pc: got %h want ffff", pc2);
      end
   endtask

   task automatic test_fetch_seq;
      rst_n = 1'b1; fetch_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_tests++;
         if ({ce_fetch, mem_we, busy, mem_addr} !== {3'b101, 16'(i)}) begin
            n_fail++; $display("FAIL fetch_issue[%0d]: got ce/we/busy/addr %b%b%b %h want 101 %h",
                               i, ce_fetch, mem_we, busy, mem_addr, 16'(i));
         end
         tick;
         n_tests++;
         if ({ce_fetch, instr_valid} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_wait[%0d]: got ce/valid %b%b want 00", i, ce_fetch, instr_valid);
         end
         tick;
         if (i == 2) fetch_en = 1'b0;
         n_tests++;
         if ({instr_valid, instr, instr_pc} !== {1'b1, exp_w[i], 16'(i)}) begin
            n_fail++; $display("FAIL fetch_data[%0d]: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h",
                               i, instr_valid, instr, instr_pc, exp_w[i], 16'(i));
         end
      end
      n_tests++;
      if (pc !== 16'h0003) begin
         n_fail++; $display("FAIL fetch_pc_end: got %h want 0003", pc);
      end
   endtask

   task automatic test_ls_priority;
      fetch_en = 1'b1;
      tick;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h00aa;
      tick;
      tick;
      n_tests++;
      if ({instr_valid, instr} !== {1'b1, 16'h1111}) begin
         n_fail++; $display("FAIL prio_fetch_done: got v=%b instr=%h want v=1 instr=1111", instr_valid, instr);
      end
      tick;
      n_tests++;
      if ({ce_alu, ce_fetch, mem_we, mem_addr} !== {3'b100, 16'h00aa}) begin
         n_fail++; $display("FAIL prio_ls_issue: got alu/fetch/we %b%b%b addr=%h want 100 00aa",
                            ce_alu, ce_fetch, mem_we, mem_addr);
      end
      tick;
      tick;
      ls_req = 1'b0; fetch_en = 1'b0;
      n_tests++;
      if ({ls_done, ls_rdata, pc} !== {1'b1, 16'h00CA, 16'h0004}) begin
         n_fail++; $display("FAIL prio_ls_done: got done=%b rdata=%h pc=%h want 1 00ca 0004",
                            ls_done, ls_rdata, pc);
      end
   endtask

   task automatic test_store_load;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'h1234;
      tick;
      n_tests++;
      if ({ce_alu, mem_we, mem_addr, mem_dina} !== {2'b11, 16'h0010, 16'h1234}) begin
         n_fail++; $display("FAIL store_issue: got alu/we %b%b addr=%h dina=%h want 11 0010 1234",
                            ce_alu, mem_we, mem_addr, mem_dina);
      end
      tick;
      n_tests++;
      if ({ce_alu, mem_we, mem_addr} !== {2'b00, 16'h0010}) begin
         n_fail++; $display("FAIL store_one_cycle: got alu/we %b%b addr=%h want 00 0010", ce_alu, mem_we, mem_addr);
      end
      tick;
      ls_we = 1'b0;
      n_tests++;
      if (ls_done !== 1'b1) begin
         n_fail++; $display("FAIL store_done: got %b want 1", ls_done);
      end
      tick;
      n_tests++;
      if ({ce_alu, mem_we} !== 2'b10) begin
         n_fail++; $display("FAIL load_issue: got alu/we %b%b want 10", ce_alu, mem_we);
      end
      tick;
      tick;
      ls_req = 1'b0;
      n_tests++;
      if ({ls_done, ls_rdata} !== {1'b1, 16'h1234}) begin
         n_fail++; $display("FAIL load_back: got done=%b rdata=%h want 1 1234", ls_done, ls_rdata);
      end
   endtask

   task automatic test_branch;
      fetch_en = 1'b1;
      tick;
      br_v = 1'b1; br_t = 16'h0040;
      tick;
      br_v = 1'b0;
      n_tests++;
      if ({busy, pc} !== {1'b1, 16'h0040}) begin
         n_fail++; $display("FAIL branch_pc: got busy=%b pc=%h want 1 0040", busy, pc);
      end
      tick;
      n_tests++;
      if ({instr_valid, busy, pc} !== {2'b00, 16'h0040}) begin
         n_fail++; $display("FAIL branch_squash: got v=%b busy=%b pc=%h want 0 0 0040", instr_valid, busy, pc);
      end
      tick;
      n_tests++;
      if ({ce_fetch, mem_addr} !== {1'b1, 16'h0040}) begin
         n_fail++; $display("FAIL branch_refetch: got ce=%b addr=%h want 1 0040", ce_fetch, mem_addr);
      end
      tick;
      tick;
      n_tests++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 16'hABCD, 16'h0040, 16'h0041}) begin
         n_fail++; $display("FAIL branch_data: got v=%b instr=%h ipc=%h pc=%h want 1 abcd 0040 0041",
                            instr_valid, instr, instr_pc, pc);
      end
      br_v = 1'b1; br_t = 16'h0005;
      tick;
      br_v = 1'b0; fetch_en = 1'b0;
      n_tests++;
      if ({ce_fetch, busy, pc} !== {2'b00, 16'h0005}) begin
         n_fail++; $display("FAIL branch_idle_suppress: got ce=%b busy=%b pc=%h want 0 0 0005", ce_fetch, busy, pc);
      end
   endtask

   task automatic test_timeout;
      int early = 0;
      suppress = 1'b1; fetch_en = 1'b1;
      tick;
      fetch_en = 1'b0;
      n_tests++;
      if ({ce_fetch, mem_addr} !== {1'b1, 16'h0005}) begin
         n_fail++; $display("FAIL tmo_issue: got ce=%b addr=%h want 1 0005", ce_fetch, mem_addr);
      end
      for (int k = 1; k < 15; k++) begin
         tick;
         if (err !== 1'b0 || busy !== 1'b1) early++;
      end
      n_tests++;
      if (early !== 0) begin
         n_fail++; $display("FAIL tmo_early: got %0d early err/idle cycles want 0", early);
      end
      tick;
      suppress = 1'b0; fetch_en = 1'b1;
      n_tests++;
      if ({err, busy, instr_valid, pc} !== {3'b100, 16'h0005}) begin
         n_fail++; $display("FAIL tmo_err: got err=%b busy=%b v=%b pc=%h want 1 0 0 0005", err, busy, instr_valid, pc);
      end
      tick;
      fetch_en = 1'b0;
      n_tests++;
      if ({err, ce_fetch, mem_addr} !== {2'b01, 16'h0005}) begin
         n_fail++; $display("FAIL tmo_refetch: got err=%b ce=%b addr=%h want 0 1 0005", err, ce_fetch, mem_addr);
      end
      tick;
      tick;
      n_tests++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 16'h5555, 16'h0005, 16'h0006}) begin
         n_fail++; $display("FAIL tmo_refetch_data: got v=%b instr=%h ipc=%h pc=%h want 1 5555 0005 0006",
                            instr_valid, instr, instr_pc, pc);
      end
   endtask

   task automatic test_reset_vector;
      int stray = 0;
      rst2_n = 1'b1; fetch_en2 = 1'b1;
      tick;
      n_tests++;
      if ({ce_fetch2, mem_addr2} !== {1'b1, 16'hFFFF}) begin
         n_fail++; $display("FAIL rv_issue: got ce=%b addr=%h want 1 ffff", ce_fetch2, mem_addr2);
      end
      tick;
      tick;
      n_tests++;
      if ({instr_valid2, instr2, instr_pc2, pc2} !== {1'b1, 16'h5A5A, 16'hFFFF, 16'h0000}) begin
         n_fail++; $display("FAIL rv_first: got v=%b instr=%h ipc=%h pc=%h want 1 5a5a ffff 0000",
                            instr_valid2, instr2, instr_pc2, pc2);
      end
      tick;
      tick;
      tick;
      n_tests++;
      if ({instr_valid2, instr2, instr_pc2, pc2} !== {1'b1, 16'h20ab, 16'h0000, 16'h0001}) begin
         n_fail++; $display("FAIL rv_wrap: got v=%b instr=%h ipc=%h pc=%h want 1 20ab 0000 0001",
                            instr_valid2, instr2, instr_pc2, pc2);
      end
      tick;
      tick;
      rst2_n = 1'b0; fetch_en2 = 1'b0;
      #1;
      n_tests++;
      if ({busy2, ce_fetch2, instr_valid2, pc2} !== {3'b000, 16'hFFFF}) begin
         n_fail++; $display("FAIL rv_midreset: got busy=%b ce=%b v=%b pc=%h want 0 0 0 ffff",
                            busy2, ce_fetch2, instr_valid2, pc2);
      end
      for (int k = 0; k < 4; k++) begin
         tick;
         if (k == 1) rst2_n = 1'b1;
         if (instr_valid2 !== 1'b0 || busy2 !== 1'b0) stray++;
      end
      n_tests++;
      if ({stray[7:0], pc2} !== {8'd0, 16'hFFFF}) begin
         n_fail++; $display("FAIL rv_no_valid: got stray=%0d pc=%h want 0 ffff", stray, pc2);
      end
      n_tests++;
      if ({ls_done2, err2, mem_we2, ce_alu2, mem_dina2, ls_rdata2} !== 36'h0) begin
         n_fail++; $display("FAIL rv_ls_idle: got %b %h %h want 0000 0000 0000",
                            {ls_done2, err2, mem_we2, ce_alu2}, mem_dina2, ls_rdata2);
      end
   endtask

   initial begin
      exp_w[0] = 16'h20ab; exp_w[1] = 16'h21cd; exp_w[2] = 16'h0B00;
      preload(16'h0000, 16'h20ab);
      preload(16'h0001, 16'h21cd);
      preload(16'h0002, 16'h0B00);
      preload(16'h0003, 16'h1111);
      preload(16'h0005, 16'h5555);
      preload(16'h00aa, 16'h00CA);
      preload(16'h0040, 16'hABCD);
      preload(16'hFFFF, 16'h5A5A);
      test_reset;
      test_fetch_seq;
      test_ls_priority;
      test_store_load;
      test_branch;
      test_timeout;
      test_reset_vector;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
